hatch_progress_ctrl: RTL
========================

// Module: hatch_progress_ctrl
// PURPOSE
//  Incubation progress controller for the egg-hatch game. Runs a tick prescaler and
//  integrates warm time into a growth stage dz_num (0..16), 16 = hatched. Flags fail
//  when the egg stays cold too long. Drives the dot-matrix image-mapping stage directly
//  with dz_num, fail and the stage-change strobe.
// PARAMETERS
//  TICK_DIV    50_000_000  clk cycles per game tick (1 s at 50 MHz); >=2
//  STEP_TICKS  3           warm ticks needed per stage increment; >=1
//  COLD_LIMIT  5           consecutive cold ticks that cause fail; >=1
//  MAX_STAGE   16          terminal (hatched) stage value; fits in 5 bits
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  start      in   1  sync 1-cycle pulse: begin or restart incubation
//  temp_hi    in   1  1 = heater warm, 0 = cold; sampled only on tick cycles
//  dz_num     out  5  current growth stage 0..MAX_STAGE
//  stage_stb  out  1  1-cycle pulse in the cycle dz_num takes a new value
//  fail       out  1  level: egg died (cold limit reached)
//  hatched    out  1  level: dz_num reached MAX_STAGE
//  busy       out  1  level: incubation in progress
// BEHAVIOUR
//  - Reset: state=IDLE; dz_num=0, stage_stb=0, fail=0, hatched=0, busy=0.
//    All counters are 0. Reset mid-incubation aborts immediately.
//  - Prescaler: pre_cnt counts 0..TICK_DIV-1 only in INCUBATE. tick=1 when
//    pre_cnt==TICK_DIV-1, then pre_cnt wraps to 0. pre_cnt is cleared on start.
//  - FSM states: IDLE, INCUBATE, HATCHED, FAILED.
//    IDLE     : start -> INCUBATE.
//    INCUBATE : busy=1. On each tick cycle:
//               temp_hi=1: cold_cnt<=0.
//                 If warm_cnt==STEP_TICKS-1: warm_cnt<=0, dz_num<=dz_num+1, stage_stb<=1.
//                 Else: warm_cnt<=warm_cnt+1.
//                 If the new dz_num==MAX_STAGE: state -> HATCHED, hatched<=1, busy<=0.
//               temp_hi=0: warm_cnt holds; cold_cnt<=cold_cnt+1.
//                 If cold_cnt==COLD_LIMIT-1: state -> FAILED, fail<=1, busy<=0.
//                 dz_num holds when fail asserts.
//               Non-tick cycles: no counter changes except pre_cnt.
//    HATCHED/FAILED: all outputs hold. start -> INCUBATE with full restart.
//  - Restart: dz_num, warm_cnt, cold_cnt and pre_cnt go to 0; fail and hatched go to 0.
//    If dz_num was non-zero, stage_stb pulses once.
//  - Latency: outputs are registered. dz_num, fail and hatched change in the cycle
//    after the tick cycle. stage_stb is high for exactly that one cycle.
//  - Simultaneous events: start coinciding with a tick in INCUBATE restarts, and the
//    tick is discarded. start in IDLE while rst=1 is ignored.
//  - Width rules: dz_num never exceeds MAX_STAGE and never wraps.
//    cold_cnt saturates at COLD_LIMIT-1 in the transition cycle.
//    warm_cnt range is 0..STEP_TICKS-1.
// TESTING  (TICK_DIV=4, STEP_TICKS=3, COLD_LIMIT=5, MAX_STAGE=16)
//  1 Reset then start, temp_hi=1 held:
//    -> stage_stb every 12 clk; dz_num 1,2,..16; hatched=1 and busy=0 after 192 clk.
//  2 Start, temp_hi=1 for 6 ticks, then 0 for 5 ticks:
//    -> dz_num=2, then fail=1 in the cycle after the 5th cold tick; dz_num stays 2.
//  3 Start, temp_hi alternating 4 cold / 1 warm ticks for 100 ticks:
//    -> fail never asserts (cold_cnt resets); dz_num advances once per 3 warm ticks.
//  4 In FAILED, pulse start:
//    -> fail=0, dz_num=0, one stage_stb, busy=1; first tick arrives 4 clk later.
//  5 Assert rst asynchronously mid-INCUBATE at dz_num=7:
//    -> outputs 0 immediately, without waiting for clk; start is required to resume.
//  6 Pulse start in the same cycle as a tick at dz_num=5:
//    -> restart; dz_num=0 next cycle; no increment from that tick.

Source files
------------

// File: rtl/hatch_progress_ctrl.sv
// Egg-hatch incubation controller: tick prescaler, warm-time growth stages, cold-death detection.
// All outputs are registered; stage/fail/hatched update the cycle after the tick that causes them.
module hatch_progress_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int STEP_TICKS = 3,
  parameter int COLD_LIMIT = 5,
  parameter int MAX_STAGE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       temp_hi,
  output logic [4:0] dz_num,
  output logic       stage_stb,
  output logic       fail,
  output logic       hatched,
  output logic       busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = $clog2(STEP_TICKS + 1);
  localparam int CW = $clog2(COLD_LIMIT + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WARM_LAST = WW'(STEP_TICKS - 1);
  localparam logic [CW-1:0] COLD_LAST = CW'(COLD_LIMIT - 1);
  localparam logic [4:0]    STAGE_MAX = 5'(MAX_STAGE);

  typedef enum logic [1:0] {IDLE, INCUBATE, HATCHED, FAILED} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre_cnt;
  logic [WW-1:0] warm_cnt;
  logic [CW-1:0] cold_cnt;
  logic          tick;
  logic          warm_step;
  logic          cold_die;

  assign tick      = (state == INCUBATE) && (pre_cnt == PRE_LAST);
  assign warm_step = tick && temp_hi && (warm_cnt == WARM_LAST);
  assign cold_die  = tick && !temp_hi && (cold_cnt == COLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // start wins over a coincident tick: the tick's effect is discarded on restart
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = INCUBATE;
    end else if (state == INCUBATE) begin
      if (warm_step && ((dz_num + 5'd1) == STAGE_MAX)) state_nxt = HATCHED;
      else if (cold_die)                               state_nxt = FAILED;
    end
  end

  always_comb begin
    busy    = (state == INCUBATE);
    fail    = (state == FAILED);
    hatched = (state == HATCHED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt   <= '0;
      warm_cnt  <= '0;
      cold_cnt  <= '0;
      dz_num    <= '0;
      stage_stb <= 1'b0;
    end else begin
      stage_stb <= 1'b0;
      if (start) begin
        pre_cnt   <= '0;
        warm_cnt  <= '0;
        cold_cnt  <= '0;
        dz_num    <= '0;
        stage_stb <= (dz_num != 5'd0);
      end else if (state == INCUBATE) begin
        pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
        if (tick) begin
          if (temp_hi) begin
            cold_cnt <= '0;
            if (warm_cnt == WARM_LAST) begin
              warm_cnt <= '0;
              if (dz_num < STAGE_MAX) begin
                dz_num    <= dz_num + 5'd1;
                stage_stb <= 1'b1;
              end
            end else begin
              warm_cnt <= warm_cnt + WW'(1);
            end
          end else if (cold_cnt != COLD_LAST) begin
            // saturates at the limit so the counter never wraps
            cold_cnt <= cold_cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule
